// File: rtl/data_mem_responder_if.sv
// Bundle of signals between the core's data port, the data memory responder
// and the UART TX/RX blocks.
//
// Handshake semantics:
//   - Core side: a request is taken on every rising edge. data_we != 0 is a
//     store, and data_re = 1 with data_we = 0 is a load. dout is registered
//     and changes only on load edges. There is no stall signal.
//   - TX side: strict valid/ready. io_tx_valid/io_tx_data stay stable until
//     the edge where io_tx_valid & io_tx_ready transfers the byte.
//   - RX side: io_rx_valid is a one-cycle pulse per byte with no backpressure.
//     The byte is taken on that edge or dropped when the FIFO is full.
interface data_mem_responder_if;
  logic [31:0] addr;
  logic [31:0] din;
  logic [3:0]  data_we;
  logic        data_re;
  logic [31:0] dout;
  logic [7:0]  io_tx_data;
  logic        io_tx_valid;
  logic        io_tx_ready;
  logic [7:0]  io_rx_data;
  logic        io_rx_valid;

  // Environment side: the core plus the UART blocks.
  modport master (
    output addr, din, data_we, data_re, io_tx_ready, io_rx_data, io_rx_valid,
    input  dout, io_tx_data, io_tx_valid
  );

  // Responder side.
  modport slave (
    input  addr, din, data_we, data_re, io_tx_ready, io_rx_data, io_rx_valid,
    output dout, io_tx_data, io_tx_valid
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: a byte-writable data RAM plus a small MMIO window
// (0xF*******) holding the UART TX/RX FIFOs and a STATUS register. Loads are
// registered with one cycle of latency, and stores never stall the core.
module data_mem_responder #(
  parameter int MEM_AW = 14,
  parameter int TX_AW  = 2,
  parameter int RX_AW  = 2
) (
  input logic                 clk,
  input logic                 rstn,
  data_mem_responder_if.slave bus
);

  localparam int MEM_WORDS = 1 << MEM_AW;
  localparam int TX_DEPTH  = 1 << TX_AW;
  localparam int RX_DEPTH  = 1 << RX_AW;

  localparam logic [3:0] OFF_TX     = 4'h0;
  localparam logic [3:0] OFF_RX     = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic              is_io;
  logic [3:0]        io_off;
  logic [MEM_AW-1:0] ram_idx;
  logic              we_any;
  logic              ld;
  logic              unused_addr_bits;

  assign is_io   = (bus.addr[31:28] == 4'hF);
  assign io_off  = bus.addr[3:0];
  assign ram_idx = bus.addr[MEM_AW+1:2];
  assign we_any  = |bus.data_we;
  // A store takes priority, so a load in the same cycle is ignored.
  assign ld      = bus.data_re && !we_any;
  // The RAM aliases, so the upper word-address and byte-offset bits are ignored.
  assign unused_addr_bits = ^bus.addr;

  // ---------------------------------------------------------------------------
  // Data RAM (not reset)
  // ---------------------------------------------------------------------------
  logic [31:0] mem [MEM_WORDS];
  logic        ram_we;

  assign ram_we = we_any && !is_io;

  // Byte-masked store. The read below samples the pre-edge word (read-first).
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_we[i]) mem[ram_idx][8*i +: 8] <= bus.din[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]     tx_buf [TX_DEPTH];
  logic [TX_AW:0] tx_wptr, tx_rptr;
  logic           tx_empty, tx_full;
  logic           tx_push_req, tx_pop, tx_accept, tx_drop_ev;

  assign tx_empty    = (tx_wptr == tx_rptr);
  assign tx_full     = (tx_wptr[TX_AW] != tx_rptr[TX_AW]) &&
                       (tx_wptr[TX_AW-1:0] == tx_rptr[TX_AW-1:0]);
  assign tx_push_req = we_any && is_io && (io_off == OFF_TX) && bus.data_we[0];
  assign tx_pop      = !tx_empty && bus.io_tx_ready;
  // A pop on the same edge frees a slot, so a push to a full FIFO still lands.
  assign tx_accept   = tx_push_req && (!tx_full || tx_pop);
  assign tx_drop_ev  = tx_push_req && tx_full && !tx_pop;

  assign bus.io_tx_valid = !tx_empty;
  assign bus.io_tx_data  = tx_empty ? 8'h00 : tx_buf[tx_rptr[TX_AW-1:0]];

  // TX storage write. Contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (tx_accept) tx_buf[tx_wptr[TX_AW-1:0]] <= bus.din[7:0];
  end

  // TX pointers advance on accepted pushes and on handshaken pops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else begin
      if (tx_accept) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)    tx_rptr <= tx_rptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]     rx_buf [RX_DEPTH];
  logic [RX_AW:0] rx_wptr, rx_rptr;
  logic           rx_empty, rx_full;
  logic           rx_pop, rx_accept, rx_ovf_ev;
  logic [7:0]     rx_head;

  assign rx_empty  = (rx_wptr == rx_rptr);
  assign rx_full   = (rx_wptr[RX_AW] != rx_rptr[RX_AW]) &&
                     (rx_wptr[RX_AW-1:0] == rx_rptr[RX_AW-1:0]);
  assign rx_head   = rx_buf[rx_rptr[RX_AW-1:0]];
  assign rx_pop    = ld && is_io && (io_off == OFF_RX) && !rx_empty;
  assign rx_accept = bus.io_rx_valid && (!rx_full || rx_pop);
  assign rx_ovf_ev = bus.io_rx_valid && rx_full && !rx_pop;

  // RX storage write.
  always_ff @(posedge clk) begin
    if (rx_accept) rx_buf[rx_wptr[RX_AW-1:0]] <= bus.io_rx_data;
  end

  // RX pointers advance on received bytes and on RX register loads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
    end else begin
      if (rx_accept) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)    rx_rptr <= rx_rptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // STATUS and sticky error bits
  // ---------------------------------------------------------------------------
  logic        rx_overflow, tx_drop;
  logic        status_rd;
  logic [31:0] status;

  assign status_rd = ld && is_io && (io_off == OFF_STATUS);
  assign status    = {28'b0, tx_drop, rx_overflow, !tx_full, !rx_empty};

  // Sticky bits are cleared by a STATUS load. A new event on the same edge wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_overflow <= 1'b0;
      tx_drop     <= 1'b0;
    end else begin
      rx_overflow <= (rx_overflow && !status_rd) || rx_ovf_ev;
      tx_drop     <= (tx_drop && !status_rd) || tx_drop_ev;
    end
  end

  // ---------------------------------------------------------------------------
  // Load path
  // ---------------------------------------------------------------------------
  logic [31:0] rd_data;

  // Select the load data from the RAM word or the MMIO register.
  always_comb begin
    rd_data = '0;
    if (is_io) begin
      case (io_off)
        OFF_RX:     rd_data = rx_empty ? 32'h0 : {24'b0, rx_head};
        OFF_STATUS: rd_data = status;
        default:    rd_data = '0;
      endcase
    end else begin
      rd_data = mem[ram_idx];
    end
  end

  // dout captures load data only on load edges and holds otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) bus.dout <= '0;
    else if (ld) bus.dout <= rd_data;
  end

endmodule
